wmem_loader: RTL and testbench

WMEM_LOADER -- requirements
Module: wmem_loader

---
 rtl/wmem_loader.sv | 114 +++++++++++
 tb/tb_wmem_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wmem_loader.sv
// Packs a byte stream into ROW_NUM-byte rows and writes each row to a weight memory
// at consecutive addresses. Define WMEM_LOADER_CHECKSUM_EN to add the o_checksum output.
module wmem_loader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ROW_NUM       = 6,
  parameter int ADDR_WIDTH    = 7,
  parameter int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [ADDR_WIDTH-1:0]    i_base_addr,
  input  logic [ADDR_WIDTH:0]      i_row_cnt,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_wr_en,
  output logic [ADDR_WIDTH-1:0]    o_wr_addr,
  output logic [ROW_WGT_WIDTH-1:0] o_wr_data,
  output logic                     o_busy,
  output logic                     o_done
`ifdef WMEM_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]    o_checksum
`endif
);

  localparam int BCW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                   state, state_nxt;
  logic [ADDR_WIDTH-1:0]    base_addr;
  logic [ADDR_WIDTH:0]      row_cnt;
  logic [ADDR_WIDTH:0]      row_idx;
  logic [BCW-1:0]           byte_cnt;
  logic [ROW_WGT_WIDTH-1:0] pack;
  logic [ROW_WGT_WIDTH-1:0] row_word;
  logic                     accept;
  logic                     row_end;
  logic                     last_row;

  assign accept   = (state == LOAD) && i_valid;
  assign row_end  = (byte_cnt == BCW'(ROW_NUM - 1));
  assign last_row = ((row_idx + (ADDR_WIDTH+1)'(1)) == row_cnt);

  assign o_ready = (state == LOAD);
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);

  // Current byte merged into the partial row, so the last byte goes straight to the write register.
  always_comb begin
    row_word = pack;
    row_word[byte_cnt*DATA_WIDTH +: DATA_WIDTH] = i_data;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = (i_row_cnt != '0) ? LOAD : DONE;
      LOAD:    if (accept && row_end && last_row) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      base_addr <= '0;
      row_cnt   <= '0;
      row_idx   <= '0;
      byte_cnt  <= '0;
      pack      <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= 1'b0;
      if ((state == IDLE) && i_start) begin
        base_addr <= i_base_addr;
        row_cnt   <= i_row_cnt;
        row_idx   <= '0;
        byte_cnt  <= '0;
        pack      <= '0;
      end else if (accept) begin
        if (row_end) begin
          byte_cnt  <= '0;
          row_idx   <= row_idx + (ADDR_WIDTH+1)'(1);
          pack      <= '0;
          o_wr_en   <= 1'b1;
          o_wr_addr <= base_addr + row_idx[ADDR_WIDTH-1:0];
          o_wr_data <= row_word;
        end else begin
          byte_cnt <= byte_cnt + BCW'(1);
          pack     <= row_word;
        end
      end
    end
  end

`ifdef WMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                      o_checksum <= '0;
    else if ((state == IDLE) && i_start) o_checksum <= '0;
    else if (accept)                   o_checksum <= o_checksum + i_data;
  end
`endif

endmodule

// File: tb/tb_wmem_loader.sv
// Directed bench for wmem_loader: single/multi-row loads, address wrap, gapped stream,
// zero-row start, ignored start while busy, and reset mid-load.
module tb_wmem_loader;
  localparam int DW = 8;
  localparam int RN = 6;
  localparam int AW = 7;
  localparam int RW = DW * RN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   row_cnt;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [RW-1:0] wr_data;
  logic          busy;
  logic          done;
`ifdef WMEM_LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  wmem_loader #(.DATA_WIDTH(DW), .ROW_NUM(RN), .ADDR_WIDTH(AW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_row_cnt   (row_cnt),
    .i_data      (data),
    .i_valid     (valid),
    .o_ready     (ready),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_busy      (busy),
    .o_done      (done)
`ifdef WMEM_LOADER_CHECKSUM_EN
    ,
    .o_checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] wa_q[$];
  logic [RW-1:0] wd_q[$];
  int            wc_q[$];
  int            dc_q[$];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wc_q.push_back(cyc);
    end
    if (done === 1'b1) dc_q.push_back(cyc);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    dc_q.delete();
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    base_addr = b;
    row_cnt   = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] b, input bit gap);
    int n;
    n     = 0;
    valid = 1'b1;
    data  = b;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", {63'd0, ready}, 64'd1);
    tick();
    if (gap) begin
      valid = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; row_cnt = '0; data = '0; valid = 1'b0;
    tick(); tick(); tick();

    chk("rst_ready",   {63'd0, ready}, 64'd0);
    chk("rst_wr_en",   {63'd0, wr_en}, 64'd0);
    chk("rst_busy",    {63'd0, busy},  64'd0);
    chk("rst_done",    {63'd0, done},  64'd0);
    chk("rst_wr_addr", 64'(wr_addr),   64'd0);
    chk("rst_wr_data", 64'(wr_data),   64'd0);
    rst_n = 1'b1;
    tick();

    // single row, valid held high
    clear_log();
    do_start(7'd0, 8'd1);
    chk("r1_busy",  {63'd0, busy},  64'd1);
    chk("r1_ready", {63'd0, ready}, 64'd1);
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    valid = 1'b0;
    chk("r1_wr_en", {63'd0, wr_en}, 64'd1);
    chk("r1_done",  {63'd0, done},  64'd1);
    chk("r1_addr",  64'(wr_addr),   64'd0);
    chk("r1_data",  64'(wr_data),   64'h060504030201);
    tick();
    chk("r1_idle_busy", {63'd0, busy},  64'd0);
    chk("r1_wr_en_off", {63'd0, wr_en}, 64'd0);
    chk("r1_hold_data", 64'(wr_data),   64'h060504030201);
    chk("r1_nwr",       64'(wa_q.size()), 64'd1);

    // two rows back-to-back
    clear_log();
    do_start(7'd2, 8'd2);
    for (int i = 'h10; i <= 'h1B; i++) send(8'(i), 1'b0);
    valid = 1'b0;
    tick(); tick();
    chk("r2_nwr",   64'(wa_q.size()), 64'd2);
    chk("r2_ndone", 64'(dc_q.size()), 64'd1);
    if (wa_q.size() == 2 && dc_q.size() == 1) begin
      chk("r2_addr0", 64'(wa_q[0]), 64'd2);
      chk("r2_data0", 64'(wd_q[0]), 64'h151413121110);
      chk("r2_addr1", 64'(wa_q[1]), 64'd3);
      chk("r2_data1", 64'(wd_q[1]), 64'h1B1A19181716);
      chk("r2_gap",   64'(wc_q[1] - wc_q[0]), 64'd6);
      chk("r2_done_with_wr", 64'(dc_q[0]), 64'(wc_q[1]));
    end

    // address wrap with gapped stream
    clear_log();
    do_start(7'd127, 8'd2);
    for (int i = 'h20; i <= 'h2B; i++) send(8'(i), 1'b1);
    tick(); tick();
    chk("r3_nwr", 64'(wa_q.size()), 64'd2);
    if (wa_q.size() == 2) begin
      chk("r3_addr0", 64'(wa_q[0]), 64'd127);
      chk("r3_data0", 64'(wd_q[0]), 64'h252423222120);
      chk("r3_addr1", 64'(wa_q[1]), 64'd0);
      chk("r3_data1", 64'(wd_q[1]), 64'h2B2A29282726);
    end

    // zero-row start
    clear_log();
    do_start(7'd9, 8'd0);
    chk("z_done",  {63'd0, done},  64'd1);
    chk("z_ready", {63'd0, ready}, 64'd0);
    tick();
    chk("z_done_off", {63'd0, done}, 64'd0);
    chk("z_idle",     {63'd0, busy}, 64'd0);
    chk("z_nwr",      64'(wa_q.size()), 64'd0);

    // start pulses during LOAD are ignored
    clear_log();
    do_start(7'd5, 8'd1);
    base_addr = 7'd9; row_cnt = 8'd0; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("ign_ready", {63'd0, ready}, 64'd1);
    for (int i = 'h30; i <= 'h35; i++) send(8'(i), 1'b0);
    valid = 1'b0;
    tick(); tick();
    chk("ign_nwr", 64'(wa_q.size()), 64'd1);
    if (wa_q.size() == 1) begin
      chk("ign_addr", 64'(wa_q[0]), 64'd5);
      chk("ign_data", 64'(wd_q[0]), 64'h353433323130);
    end

    // reset after three bytes of a row
    clear_log();
    do_start(7'd10, 8'd1);
    for (int i = 'h40; i <= 'h42; i++) send(8'(i), 1'b0);
    valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mr_ready",   {63'd0, ready}, 64'd0);
    chk("mr_busy",    {63'd0, busy},  64'd0);
    chk("mr_done",    {63'd0, done},  64'd0);
    chk("mr_wr_en",   {63'd0, wr_en}, 64'd0);
    chk("mr_wr_addr", 64'(wr_addr),   64'd0);
    chk("mr_wr_data", 64'(wr_data),   64'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("mr_nwr", 64'(wa_q.size()), 64'd0);
    do_start(7'd11, 8'd1);
    for (int i = 'h50; i <= 'h55; i++) send(8'(i), 1'b0);
    valid = 1'b0;
    chk("mr2_wr_en", {63'd0, wr_en}, 64'd1);
    chk("mr2_addr",  64'(wr_addr),   64'd11);
    chk("mr2_data",  64'(wr_data),   64'h555453525150);
    tick(); tick();

`ifdef WMEM_LOADER_CHECKSUM_EN
    do_start(7'd0, 8'd1);
    chk("cs_clear", 64'(checksum), 64'd0);
    send(8'hFF, 1'b0);
    send(8'h02, 1'b0);
    for (int i = 0; i < 4; i++) send(8'h00, 1'b0);
    valid = 1'b0;
    tick(); tick();
    chk("cs_sum", 64'(checksum), 64'h01);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
